// File: rtl/sd_sector_sequencer.sv
// Multi-sector read sequencer for the SPI sd_controller: issues rd per sector and forwards bytes.
// Optional watchdog: define SD_SEQ_TIMEOUT_EN (adds TIMEOUT_CYCLES and a live error_out).
module sd_sector_sequencer #(
  parameter int SECTOR_BYTES  = 512,
  parameter int SECTOR_STRIDE = 512,
  parameter int COUNT_W       = 16
`ifdef SD_SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 2_000_000
`endif
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               start_in,
  input  logic               abort_in,
  input  logic [31:0]        start_addr_in,
  input  logic [COUNT_W-1:0] num_sectors_in,
  input  logic               hold_in,
  input  logic               sd_ready_in,
  input  logic               sd_byte_available_in,
  input  logic [7:0]         sd_dout_in,
  output logic               sd_rd_out,
  output logic [31:0]        sd_addr_out,
  output logic [7:0]         byte_out,
  output logic               byte_valid_out,
  output logic               sector_done_out,
  output logic [COUNT_W-1:0] sectors_done_out,
  output logic               busy_out,
  output logic               done_out,
  output logic               error_out
);

  localparam int BCNT_W = $clog2(SECTOR_BYTES + 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_READY,
    ISSUE,
    READ,
    NEXT,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [COUNT_W-1:0] sectors_done_q, sectors_done_d;
  logic [BCNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic               prev_avail_q;
  logic               abort_pending_q, abort_pending_d;
  logic               rd_q, rd_d;
  logic [7:0]         byte_q, byte_d;
  logic               byte_valid_q, byte_valid_d;
  logic               sector_done_q, sector_done_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               byte_edge;

  assign byte_edge = sd_byte_available_in & ~prev_avail_q;

`ifdef SD_SEQ_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              error_q, error_d;
  logic              wdog_expired;

  assign wdog_expired = (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1));
  assign error_out    = error_q;
`else
  assign error_out    = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    count_d         = count_q;
    sectors_done_d  = sectors_done_q;
    byte_cnt_d      = byte_cnt_q;
    abort_pending_d = abort_pending_q;
    rd_d            = rd_q;
    byte_d          = byte_q;
    byte_valid_d    = 1'b0;
    sector_done_d   = 1'b0;
    busy_d          = busy_q;
    done_d          = 1'b0;
`ifdef SD_SEQ_TIMEOUT_EN
    error_d         = error_q;
    wdog_d          = '0;
`endif

    case (state_q)
      IDLE: begin
        if (start_in) begin
          if (num_sectors_in == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d         = start_addr_in;
            count_d        = num_sectors_in;
            sectors_done_d = '0;
            busy_d         = 1'b1;
            state_d        = WAIT_READY;
`ifdef SD_SEQ_TIMEOUT_EN
            error_d        = 1'b0;
`endif
          end
        end
      end

      WAIT_READY: begin
        if (abort_pending_q || abort_in) begin
          state_d = DONE;
        end else if (sd_ready_in && !hold_in) begin
          rd_d    = 1'b1;
          state_d = ISSUE;
        end
      end

      // rd stays high until the controller drops ready, meaning it took the command
      ISSUE: begin
        if (abort_in) abort_pending_d = 1'b1;
        if (!sd_ready_in) begin
          rd_d       = 1'b0;
          byte_cnt_d = '0;
          state_d    = READ;
        end
`ifdef SD_SEQ_TIMEOUT_EN
        else if (wdog_expired) begin
          error_d = 1'b1;
          rd_d    = 1'b0;
          state_d = DONE;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
`endif
      end

      READ: begin
        if (abort_in) abort_pending_d = 1'b1;
        if (byte_edge) begin
          byte_d       = sd_dout_in;
          byte_valid_d = 1'b1;
          byte_cnt_d   = byte_cnt_q + BCNT_W'(1);
          if (byte_cnt_q == BCNT_W'(SECTOR_BYTES - 1)) state_d = NEXT;
        end
`ifdef SD_SEQ_TIMEOUT_EN
        else if (wdog_expired) begin
          error_d = 1'b1;
          rd_d    = 1'b0;
          state_d = DONE;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
`endif
      end

      NEXT: begin
        sector_done_d  = 1'b1;
        sectors_done_d = sectors_done_q + COUNT_W'(1);
        addr_d         = addr_q + 32'(SECTOR_STRIDE);
        if ((sectors_done_d == count_q) || abort_pending_q) state_d = DONE;
        else                                                state_d = WAIT_READY;
      end

      DONE: begin
        done_d          = 1'b1;
        busy_d          = 1'b0;
        abort_pending_d = 1'b0;
        state_d         = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      count_q         <= '0;
      sectors_done_q  <= '0;
      byte_cnt_q      <= '0;
      prev_avail_q    <= 1'b0;
      abort_pending_q <= 1'b0;
      rd_q            <= 1'b0;
      byte_q          <= '0;
      byte_valid_q    <= 1'b0;
      sector_done_q   <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
`ifdef SD_SEQ_TIMEOUT_EN
      error_q         <= 1'b0;
      wdog_q          <= '0;
`endif
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      count_q         <= count_d;
      sectors_done_q  <= sectors_done_d;
      byte_cnt_q      <= byte_cnt_d;
      prev_avail_q    <= sd_byte_available_in;
      abort_pending_q <= abort_pending_d;
      rd_q            <= rd_d;
      byte_q          <= byte_d;
      byte_valid_q    <= byte_valid_d;
      sector_done_q   <= sector_done_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
`ifdef SD_SEQ_TIMEOUT_EN
      error_q         <= error_d;
      wdog_q          <= wdog_d;
`endif
    end
  end

  assign sd_rd_out        = rd_q;
  assign sd_addr_out      = addr_q;
  assign byte_out         = byte_q;
  assign byte_valid_out   = byte_valid_q;
  assign sector_done_out  = sector_done_q;
  assign sectors_done_out = sectors_done_q;
  assign busy_out         = busy_q;
  assign done_out         = done_q;

endmodule

// File: tb/tb_sd_sector_sequencer.sv
// Scoreboard bench for sd_sector_sequencer: an sd_controller model queues expected bytes/addresses,
// a negedge monitor pops and compares them whenever the DUT presents a byte or raises rd.
`timescale 1ns/1ps
module tb_sd_sector_sequencer;

  localparam int SB = 512;
  localparam int CW = 16;
`ifdef SD_SEQ_TIMEOUT_EN
  localparam int TO = 1000;
`endif

  logic          clk_in = 1'b0;
  logic          rst_n_in = 1'b0;
  logic          start_in = 1'b0;
  logic          abort_in = 1'b0;
  logic [31:0]   start_addr_in = '0;
  logic [CW-1:0] num_sectors_in = '0;
  logic          hold_in = 1'b0;
  logic          sd_ready_in = 1'b1;
  logic          sd_byte_available_in = 1'b0;
  logic [7:0]    sd_dout_in = '0;
  logic          sd_rd_out;
  logic [31:0]   sd_addr_out;
  logic [7:0]    byte_out;
  logic          byte_valid_out;
  logic          sector_done_out;
  logic [CW-1:0] sectors_done_out;
  logic          busy_out;
  logic          done_out;
  logic          error_out;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0]  exp_bytes[$];
  logic [31:0] exp_addrs[$];

  int     n_valid = 0, n_sector_done = 0, n_done = 0, n_rd = 0;
  longint cyc = 0, last_valid_cyc = 0, done_cyc = 0, error_cyc = 0;
  int     high_cycles = 1;
  int     stall_at = -1;
  bit     model_abandon = 1'b0;
  bit     model_busy = 1'b0;
  logic   prev_rd = 1'b0, prev_err = 1'b0;

  sd_sector_sequencer #(
    .SECTOR_BYTES(SB),
    .SECTOR_STRIDE(512),
    .COUNT_W(CW)
`ifdef SD_SEQ_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TO)
`endif
  ) dut (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
    .start_in(start_in),
    .abort_in(abort_in),
    .start_addr_in(start_addr_in),
    .num_sectors_in(num_sectors_in),
    .hold_in(hold_in),
    .sd_ready_in(sd_ready_in),
    .sd_byte_available_in(sd_byte_available_in),
    .sd_dout_in(sd_dout_in),
    .sd_rd_out(sd_rd_out),
    .sd_addr_out(sd_addr_out),
    .byte_out(byte_out),
    .byte_valid_out(byte_valid_out),
    .sector_done_out(sector_done_out),
    .sectors_done_out(sectors_done_out),
    .busy_out(busy_out),
    .done_out(done_out),
    .error_out(error_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc++;

  initial begin
    #600_000;
    $display("[TB] FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "[TB] global timeout");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [7:0] dataOf(input logic [31:0] a, input int i);
    return 8'(i) ^ a[16:9] ^ 8'hA5;
  endfunction

  // Scoreboard monitor: compares each forwarded byte and each rd address against the queues
  always @(negedge clk_in) begin
    if (rst_n_in) begin
      if (byte_valid_out) begin
        n_valid++;
        last_valid_cyc = cyc;
        if (exp_bytes.size() == 0) checkOutput("byte_queue_empty", 32'(1), 32'(0));
        else                       checkOutput("byte_data", 32'(byte_out), 32'(exp_bytes.pop_front()));
      end
      if (sd_rd_out && !prev_rd) begin
        n_rd++;
        if (exp_addrs.size() == 0) checkOutput("rd_unexpected", sd_addr_out, 32'hFFFF_FFFF);
        else                       checkOutput("rd_addr", sd_addr_out, exp_addrs.pop_front());
      end
      if (sector_done_out) n_sector_done++;
      if (done_out) begin
        n_done++;
        done_cyc = cyc;
      end
      if (error_out && !prev_err) error_cyc = cyc;
    end
    prev_rd  = sd_rd_out;
    prev_err = error_out;
  end

  // sd_controller model: accepts rd, drops ready, delivers SB bytes, raises ready again
  initial begin : ctrl_model
    logic [31:0] cur_addr;
    forever begin
      @(posedge clk_in); #1;
      if (sd_rd_out === 1'b1) begin
        model_busy = 1'b1;
        cur_addr   = sd_addr_out;
        repeat (2) begin @(posedge clk_in); #1; end
        sd_ready_in = 1'b0;
        for (int i = 0; i < SB; i++) begin
          @(posedge clk_in); #1;
          if (model_abandon) break;
          if (i == stall_at) begin
            while (!model_abandon) begin @(posedge clk_in); #1; end
            break;
          end
          sd_dout_in           = dataOf(cur_addr, i);
          sd_byte_available_in = 1'b1;
          exp_bytes.push_back(sd_dout_in);
          repeat (high_cycles) begin @(posedge clk_in); #1; end
          sd_byte_available_in = 1'b0;
        end
        sd_byte_available_in = 1'b0;
        @(posedge clk_in); #1;
        sd_ready_in = 1'b1;
        model_busy  = 1'b0;
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] addr, input int n);
    @(posedge clk_in); #1;
    start_addr_in  = addr;
    num_sectors_in = CW'(n);
    start_in       = 1'b1;
    @(posedge clk_in); #1;
    start_in       = 1'b0;
  endtask

  task automatic resetCounters();
    n_valid = 0; n_sector_done = 0; n_done = 0; n_rd = 0;
  endtask

  task automatic waitDone(input int target, input int budget);
    int c = 0;
    while (n_done < target && c < budget) begin @(posedge clk_in); c++; end
    checkOutput("done_wait", 32'(n_done >= target), 32'(1));
  endtask

  task automatic waitValid(input int target, input int budget);
    int c = 0;
    while (n_valid < target && c < budget) begin @(posedge clk_in); c++; end
    checkOutput("valid_wait", 32'(n_valid >= target), 32'(1));
  endtask

  task automatic waitModelIdle();
    int c = 0;
    while (model_busy && c < 4000) begin @(posedge clk_in); c++; end
    checkOutput("model_idle_wait", 32'(model_busy), 32'(0));
    repeat (3) @(posedge clk_in);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_rd"}, 32'(sd_rd_out), 32'(0));
    checkOutput({tag, "_addr"}, sd_addr_out, 32'(0));
    checkOutput({tag, "_byte"}, 32'(byte_out), 32'(0));
    checkOutput({tag, "_valid"}, 32'(byte_valid_out), 32'(0));
    checkOutput({tag, "_sector_done"}, 32'(sector_done_out), 32'(0));
    checkOutput({tag, "_sectors_done"}, 32'(sectors_done_out), 32'(0));
    checkOutput({tag, "_busy"}, 32'(busy_out), 32'(0));
    checkOutput({tag, "_done"}, 32'(done_out), 32'(0));
    checkOutput({tag, "_error"}, 32'(error_out), 32'(0));
  endtask

  initial begin
    int c;
    int hold_viol;

    #12;
    checkIdleOutputs("reset");
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;
    repeat (2) @(posedge clk_in);

    // Two-sector read starting at 0x200
    resetCounters();
    exp_addrs.push_back(32'h200);
    exp_addrs.push_back(32'h400);
    applyStimulus(32'h200, 2);
    waitDone(1, 6000);
    @(negedge clk_in);
    checkOutput("t1_bytes", 32'(n_valid), 32'(1024));
    checkOutput("t1_sector_done", 32'(n_sector_done), 32'(2));
    checkOutput("t1_done", 32'(n_done), 32'(1));
    checkOutput("t1_rd_count", 32'(n_rd), 32'(2));
    checkOutput("t1_sectors_done", 32'(sectors_done_out), 32'(2));
    checkOutput("t1_busy", 32'(busy_out), 32'(0));
    checkOutput("t1_bytes_left", 32'(exp_bytes.size()), 32'(0));
    waitModelIdle();

    // Zero-sector request completes immediately
    resetCounters();
    applyStimulus(32'h1000, 0);
    @(negedge clk_in);
    checkOutput("t2_done_pulse", 32'(done_out), 32'(1));
    checkOutput("t2_busy", 32'(busy_out), 32'(0));
    @(negedge clk_in);
    checkOutput("t2_done_low", 32'(done_out), 32'(0));
    checkOutput("t2_busy_after", 32'(busy_out), 32'(0));
    repeat (5) @(posedge clk_in);
    checkOutput("t2_rd_count", 32'(n_rd), 32'(0));

    // Abort at byte 100 of the first sector of five
    resetCounters();
    exp_addrs.push_back(32'h3000);
    applyStimulus(32'h3000, 5);
    waitValid(100, 2000);
    @(posedge clk_in); #1;
    abort_in = 1'b1;
    @(posedge clk_in); #1;
    abort_in = 1'b0;
    waitDone(1, 4000);
    repeat (10) @(posedge clk_in);
    checkOutput("t3_bytes", 32'(n_valid), 32'(512));
    checkOutput("t3_sector_done", 32'(n_sector_done), 32'(1));
    checkOutput("t3_rd_count", 32'(n_rd), 32'(1));
    checkOutput("t3_sectors_done", 32'(sectors_done_out), 32'(1));
    checkOutput("t3_done", 32'(n_done), 32'(1));
    waitModelIdle();

    // hold_in between sectors blocks the next rd for 50 cycles
    resetCounters();
    exp_addrs.push_back(32'h8000);
    exp_addrs.push_back(32'h8200);
    applyStimulus(32'h8000, 2);
    c = 0;
    while (n_rd < 1 && c < 100) begin @(posedge clk_in); c++; end
    #1 hold_in = 1'b1;
    c = 0;
    while (n_sector_done < 1 && c < 3000) begin @(posedge clk_in); c++; end
    checkOutput("t4_first_sector", 32'(n_sector_done), 32'(1));
    hold_viol = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk_in);
      if (sd_rd_out) hold_viol++;
    end
    checkOutput("t4_rd_during_hold", 32'(hold_viol), 32'(0));
    @(posedge clk_in); #1;
    hold_in = 1'b0;
    @(negedge clk_in);
    checkOutput("t4_rd_same_cycle", 32'(sd_rd_out), 32'(0));
    @(negedge clk_in);
    checkOutput("t4_rd_after_release", 32'(sd_rd_out), 32'(1));
    waitDone(1, 3000);
    checkOutput("t4_bytes", 32'(n_valid), 32'(1024));
    checkOutput("t4_rd_count", 32'(n_rd), 32'(2));
    waitModelIdle();

    // Long byte_available level plus an ignored second start
    resetCounters();
    high_cycles = 4;
    exp_addrs.push_back(32'hA000);
    applyStimulus(32'hA000, 1);
    waitValid(50, 1000);
    applyStimulus(32'hF000, 3);
    waitDone(1, 5000);
    repeat (10) @(posedge clk_in);
    checkOutput("t5_bytes", 32'(n_valid), 32'(512));
    checkOutput("t5_rd_count", 32'(n_rd), 32'(1));
    checkOutput("t5_sectors_done", 32'(sectors_done_out), 32'(1));
    checkOutput("t5_done", 32'(n_done), 32'(1));
    waitModelIdle();
    high_cycles = 1;

    // Asynchronous reset in the middle of READ
    resetCounters();
    exp_addrs.push_back(32'hC000);
    applyStimulus(32'hC000, 2);
    waitValid(20, 1000);
    model_abandon = 1'b1;
    #3 rst_n_in = 1'b0;
    #1 checkIdleOutputs("mid_reset");
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;
    waitModelIdle();
    exp_bytes.delete();
    exp_addrs.delete();
    model_abandon = 1'b0;

    // Recovery after reset
    resetCounters();
    exp_addrs.push_back(32'hE00);
    applyStimulus(32'hE00, 1);
    waitDone(1, 3000);
    checkOutput("t7_bytes", 32'(n_valid), 32'(512));
    checkOutput("t7_sectors_done", 32'(sectors_done_out), 32'(1));
    waitModelIdle();

`ifdef SD_SEQ_TIMEOUT_EN
    // Controller stalls after 10 bytes; watchdog ends the transfer
    resetCounters();
    stall_at = 10;
    exp_addrs.push_back(32'h400);
    applyStimulus(32'h400, 1);
    waitDone(1, 3000);
    @(negedge clk_in);
    checkOutput("to_error", 32'(error_out), 32'(1));
    checkOutput("to_bytes", 32'(n_valid), 32'(10));
    checkOutput("to_error_latency", 32'(error_cyc - last_valid_cyc), 32'(TO));
    checkOutput("to_done_latency", 32'(done_cyc - last_valid_cyc), 32'(TO + 1));
    checkOutput("to_rd", 32'(sd_rd_out), 32'(0));
    model_abandon = 1'b1;
    waitModelIdle();
    model_abandon = 1'b0;
    stall_at = -1;
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
